// File: rtl/rot13_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rot13_pkg
// Description : Shared types and constants for the ROT13 byte feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package rot13_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_LO = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_XLATE   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } feeder_state_e;

    localparam logic [1:0] CTL_LO    = 2'b00;
    localparam logic [1:0] CTL_HI    = 2'b01;
    localparam logic [1:0] CTL_XLATE = 2'b10;

    localparam logic [7:0] ACK_LO_DEFAULT = 8'h0F;
    localparam logic [7:0] ACK_HI_DEFAULT = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/rot13_feeder_ack_chk.sv
`default_nettype none
// ============================================================================
// Module      : rot13_feeder_ack_chk
// Description : Compares the cipher response against the expected nibble-load
//               acknowledges on per-state strobes; owns the sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rot13_feeder_ack_chk
    import rot13_pkg::*;
#(
    parameter logic [7:0] ACK_LO = ACK_LO_DEFAULT,
    parameter logic [7:0] ACK_HI = ACK_HI_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chk_lo_i,
    input  logic       chk_hi_i,
    input  logic [7:0] rsp_i,
    output logic       err_o
);

    logic err_q;
    logic err_d;
    logic w_mismatch;

    assign w_mismatch = (chk_lo_i && (rsp_i != ACK_LO)) ||
                        (chk_hi_i && (rsp_i != ACK_HI));

    always_comb begin
        err_d = err_q | w_mismatch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule
`default_nettype wire

// File: rtl/rot13_byte_feeder.sv
`default_nettype none
// ============================================================================
// Module      : rot13_byte_feeder
// Description : Byte-wide valid/ready front end for the nibble-loaded ROT13
//               cipher: loads low/high nibble, translates, captures result.
//               Optional ack checking via ROT13_FEEDER_ACK_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rot13_byte_feeder
    import rot13_pkg::*;
#(
    parameter logic [7:0] ACK_LO = ACK_LO_DEFAULT,
    parameter logic [7:0] ACK_HI = ACK_HI_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] cph_ctl,
    output logic [3:0] cph_data,
    input  logic [7:0] cph_rsp,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err
);

    feeder_state_e state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    // Gated by reset so the feeder never advertises readiness while held.
    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cph_ctl     = CTL_XLATE;
        cph_data    = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    byte_d  = in_data;
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                cph_ctl  = CTL_LO;
                cph_data = byte_q[3:0];
                state_d  = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                cph_ctl  = CTL_HI;
                cph_data = byte_q[7:4];
                state_d  = ST_XLATE;
            end
            ST_XLATE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                out_data_d  = cph_rsp;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef ROT13_FEEDER_ACK_CHECK_EN
    logic w_chk_lo;
    logic w_chk_hi;

    // The cipher's response to a load is visible one state after issuing it.
    assign w_chk_lo = (state_q == ST_SEND_HI);
    assign w_chk_hi = (state_q == ST_XLATE);

    rot13_feeder_ack_chk #(
        .ACK_LO (ACK_LO),
        .ACK_HI (ACK_HI)
    ) u_ack_chk (
        .clk      (clk),
        .reset    (reset),
        .chk_lo_i (w_chk_lo),
        .chk_hi_i (w_chk_hi),
        .rsp_i    (cph_rsp),
        .err_o    (err)
    );
`else
    logic [15:0] w_unused_ack;
    assign w_unused_ack = {ACK_LO, ACK_HI};
    assign err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rot13_byte_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rot13_byte_feeder
// Description : Scoreboard bench for rot13_byte_feeder with a behavioural
//               nibble-loaded ROT13 cipher (optionally stuck at 0x00).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rot13_byte_feeder;

`ifdef ROT13_FEEDER_ACK_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] cph_ctl;
    logic [3:0] cph_data;
    logic [7:0] cph_rsp;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;

    rot13_byte_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cph_ctl   (cph_ctl),
        .cph_data  (cph_data),
        .cph_rsp   (cph_rsp),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural cipher: registered ack after each nibble load, ROT13 on translate.
    logic [3:0] c_lo, c_hi;
    logic       stuck = 1'b0;

    function automatic logic [7:0] rot13(input logic [7:0] b);
        int v;
        v = int'(b);
        if (b[7])                 return 8'h00;
        if (v >= 65 && v <= 90)   return 8'(((v - 65 + 13) % 26) + 65);
        if (v >= 97 && v <= 122)  return 8'(((v - 97 + 13) % 26) + 97);
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            c_lo    <= 4'h0;
            c_hi    <= 4'h0;
            cph_rsp <= 8'h00;
        end else if (cph_ctl == 2'b00) begin
            c_lo    <= cph_data;
            cph_rsp <= stuck ? 8'h00 : 8'h0F;
        end else if (cph_ctl == 2'b01) begin
            c_hi    <= cph_data;
            cph_rsp <= stuck ? 8'h00 : 8'hF0;
        end else begin
            cph_rsp <= stuck ? 8'h00 : rot13({c_hi, c_lo});
        end
    end

    typedef struct {
        logic [7:0] exp;
        time        t_acc;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks latency on out_valid rise and data on each handshake.
    logic prev_valid = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("latency_ns", 32'(($time - 7) - exp_q[0].t_acc), 32'd40);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                sb_entry_t e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.exp));
            end
        end
        prev_valid = out_valid;
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [7:0] d, input logic [7:0] exp,
                        input logic keep, output time t_acc);
        int n;
        sb_entry_t e;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        t_acc = 0;
        while (!in_ready) begin
            if (n == 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        t_acc   = $time;
        e.exp   = exp;
        e.t_acc = t_acc;
        exp_q.push_back(e);
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || busy) begin
            if (n == 200) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        time t0, t1, t2;
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cph_ctl", 32'(cph_ctl), 32'h2);
        chk("rst_cph_data", 32'(cph_data), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 'A' -> 'N', with nibble sequence observed on the cipher pins
        send(8'h41, 8'h4E, 1'b0, t0);
        chk("lo_ctl", 32'(cph_ctl), 32'h0);
        chk("lo_data", 32'(cph_data), 32'h1);
        @(negedge clk);
        chk("hi_ctl", 32'(cph_ctl), 32'h1);
        chk("hi_data", 32'(cph_data), 32'h4);
        @(negedge clk);
        chk("xl_ctl", 32'(cph_ctl), 32'h2);
        chk("xl_data", 32'(cph_data), 32'h0);
        wait_drain();
        chk("err_after_A", 32'(err), 32'd0);

        // back-to-back with in_valid held high
        send(8'h7A, 8'h6D, 1'b1, t0);
        send(8'h6E, 8'h61, 1'b1, t1);
        send(8'h5B, 8'h5B, 1'b0, t2);
        chk("gap1_ns", 32'(t1 - t0), 32'd60);
        chk("gap2_ns", 32'(t2 - t1), 32'd60);
        wait_drain();

        send(8'h80, 8'h00, 1'b0, t0);
        wait_drain();
        chk("err_after_80", 32'(err), 32'd0);

        // downstream stall
        out_ready = 1'b0;
        send(8'h30, 8'h30, 1'b0, t0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'h30);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // reset while in XLATE
        send(8'h61, 8'h6E, 1'b0, t0);
        @(negedge clk);
        @(negedge clk);
        chk("in_xlate_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cph_ctl", 32'(cph_ctl), 32'h2);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_out_valid", 32'(out_valid), 32'd0);
        send(8'h61, 8'h6E, 1'b0, t0);
        wait_drain();

        // cipher stuck at 0x00
        stuck = 1'b1;
        @(negedge clk);
        send(8'h41, 8'h00, 1'b0, t0);
        chk("stuck_err_e0", 32'(err), 32'd0);
        @(negedge clk);
        chk("stuck_err_e1", 32'(err), 32'd0);
        @(negedge clk);
        chk("stuck_err_e2", 32'(err), 32'(EXP_ERR));
        wait_drain();
        repeat (3) @(negedge clk);
        chk("stuck_err_persist", 32'(err), 32'(EXP_ERR));

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rot13_byte_feeder.md
# rot13_byte_feeder

Byte-stream front end for the nibble-loaded ROT13 cipher stage. It accepts whole ASCII bytes over a valid/ready handshake and drives the cipher's 2-bit control and 4-bit data pins as a sequence: low nibble, then high nibble, then translate. It captures the translated byte from the cipher's 8-bit registered output and presents it over a second valid/ready handshake. It sits directly upstream of the cipher and also consumes its output, so the cipher can be exercised one byte per transaction.

## Interface
Parameters:
- `ACK_LO`, default 8'h0F: cipher response expected after a low-nibble load.
- `ACK_HI`, default 8'hF0: cipher response expected after a high-nibble load.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  8  byte to translate.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  feeder can accept a byte.
- `cph_ctl`  out  2  to cipher control pins. 00 = load low nibble, 01 = load high nibble, 1x = translate.
- `cph_data`  out  4  to cipher data-nibble pins.
- `cph_rsp`  in  8  cipher registered output.
- `out_data`  out  8  translated byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky acknowledge-mismatch flag.

## Operation
The FSM states are IDLE, SEND_LO, SEND_HI, XLATE, CAPTURE and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_data` into `byte_q` and go to SEND_LO.
- **SEND_LO**
  - Drive `cph_ctl`=00 and `cph_data`=`byte_q[3:0]`.
  - Go to SEND_HI.
- **SEND_HI**
  - Drive `cph_ctl`=01 and `cph_data`=`byte_q[7:4]`.
  - Go to XLATE.
- **XLATE**
  - Drive `cph_ctl`=10 and `cph_data`=0.
  - Go to CAPTURE.
- **CAPTURE**
  - Drive `cph_ctl`=10.
  - At the edge, load `out_data`<=`cph_rsp` and `out_valid`<=1, then go to DONE.
- **DONE**
  - Hold `out_data` and `out_valid`.
  - On `out_ready`, clear `out_valid` and go to IDLE.
- **Outside SEND_LO, SEND_HI and XLATE**
  - `cph_ctl`=10 and `cph_data`=0. The translate code leaves the cipher's stored nibbles unchanged.
- **Data path**
  - The byte passes through unmodified.
  - For inputs 0x80..0xFF the cipher returns 0x00, and the feeder forwards 0x00 without flagging it.
- **Input hold**
  - `in_data` is sampled only at the accept edge.
  - Changes to `in_data` or `in_valid` while busy have no effect.

## Timing
- Accept edge E0. Cipher loads the low nibble at E1 and the high nibble at E2, and computes the translation at E3.
- `out_data` is loaded at E4; `out_valid` is high from E4. Latency is 4 cycles from accept to `out_valid`.
- Minimum period is 6 cycles per byte with `out_ready` tied high: the next accept is possible on the cycle after the DONE handshake.
- Acknowledge checks (only with the macro):
  - `cph_rsp` is sampled at E2 (must equal `ACK_LO`) and at E3 (must equal `ACK_HI`).
  - A mismatch sets `err` at that edge. The byte still completes normally.
- Reset values:
  - `in_ready`=0 during reset, 1 on the first cycle after reset.
  - `out_valid`=0, `out_data`=0x00, `busy`=0, `err`=0, `cph_ctl`=10, `cph_data`=0; FSM in IDLE.
- Reset mid-transaction abandons the byte and produces no output. The cipher shares `reset`, so both restart cleanly.
- `out_ready` asserted while `out_valid`=0 is ignored.
- `in_valid` asserted in the same cycle as the DONE handshake is not accepted until the following IDLE cycle.

## Configuration
- `ROT13_FEEDER_ACK_CHECK_EN` defined:
  - Both acknowledge comparisons are instantiated.
  - `err` is sticky until reset.
- Not defined:
  - Comparators are removed and `err` is tied 0.
  - Sequencing and latency are identical.

## Structure
- Shared package `rot13_pkg` holds:
  - the state enum;
  - `CTL_LO`=2'b00, `CTL_HI`=2'b01, `CTL_XLATE`=2'b10;
  - default `ACK_LO` and `ACK_HI` constants.
- One sub-module, `rot13_feeder_ack_chk`, instantiated only under the macro. It compares `cph_rsp` against the expected ack on a per-state strobe and owns the sticky `err` register.
- The FSM, nibble mux and output register stay in the top module.

## Test plan
- Reset, then send 0x41 ('A') with `out_ready`=1:
  - `cph_ctl` sequence 00/01/10 carries `cph_data` 1 then 4.
  - `out_data`=0x4E, `out_valid` high exactly 4 cycles after accept, `err`=0.
- Back-to-back input 0x7A, 0x6E, 0x5B with `in_valid` held high:
  - outputs 0x6D, 0x61, 0x5B;
  - accepts spaced 6 cycles apart.
- Send 0x80 → `out_data`=0x00, `err`=0.
- Send 0x30, hold `out_ready`=0 for 10 cycles:
  - `out_valid` and `out_data`=0x30 stay stable;
  - `in_ready`=0 throughout;
  - handshake on the cycle `out_ready` rises, then IDLE.
- Assert `reset` in XLATE while translating 0x61:
  - next cycle `out_valid`=0, `busy`=0, `cph_ctl`=10;
  - the following byte 0x61 yields 0x6E.
- Replace the cipher with a model whose `cph_rsp` sticks at 0x00:
  - with `ROT13_FEEDER_ACK_CHECK_EN`, `err`=1 from E2 and it persists;
  - without the macro, `err`=0.
